// File: rtl/tomasulo_pkg.sv
// Shared types and defaults for the Tomasulo front end.
package tomasulo_pkg;

    localparam int XLEN              = 32;
    localparam int IFQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue.sv
// Fetch-to-issue decoupling FIFO of {pc, instr} pairs with flush and almost_full.
// Define IFQ_BYPASS_EN to let an empty queue pass fetch straight to issue in the same cycle.
module instr_fetch_queue
    import tomasulo_pkg::*;
#(
    parameter int DEPTH     = IFQ_DEPTH_DEFAULT,
    parameter int AF_MARGIN = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    fetch_valid,
    input  logic [XLEN-1:0]         fetch_pc,
    input  logic [XLEN-1:0]         fetch_instr,
    output logic                    fetch_ready,
    output logic                    almost_full,
    output logic                    issue_valid,
    output logic [XLEN-1:0]         issue_pc,
    output logic [XLEN-1:0]         issue_instr,
    input  logic                    issue_stall,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

    fetch_entry_t  entries_q [DEPTH];
    fetch_entry_t  head;
    fetch_entry_t  fetch_entry;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          head_valid;
    logic          bypass;
    logic          enq, deq;
    logic          write_en, pop_en;

    assign fetch_entry = '{pc: fetch_pc, instr: fetch_instr};
    assign head        = entries_q[rd_ptr_q];
    assign head_valid  = (count_q != '0);

`ifdef IFQ_BYPASS_EN
    assign bypass = (count_q == '0) & fetch_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // Ready depends on occupancy only, so a stall never reaches fetch combinationally.
    assign fetch_ready = (count_q < FULL_CNT);
    assign almost_full = (count_q >= AF_CNT);
    assign count       = count_q;

    assign enq = fetch_valid & fetch_ready & ~flush;
    assign deq = issue_valid & ~issue_stall & ~flush;

    // A bypassed instruction that issues immediately is never stored.
    assign write_en = enq & ~(bypass & deq);
    assign pop_en   = deq & head_valid;

    always_comb begin
        issue_valid = head_valid | bypass;
        issue_pc    = '0;
        issue_instr = '0;
        if (head_valid) begin
            issue_pc    = head.pc;
            issue_instr = head.instr;
        end else if (bypass) begin
            issue_pc    = fetch_pc;
            issue_instr = fetch_instr;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (write_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_en)   rd_ptr_d = rd_ptr_q + PW'(1);
            case ({write_en, pop_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: validity is carried by count_q.
    always_ff @(posedge clk) begin
        if (write_en) begin
            entries_q[wr_ptr_q] <= fetch_entry;
        end
    end

    count_bound_a: assert property (@(posedge clk) disable iff (reset) count_q <= FULL_CNT);

endmodule
